// File: rtl/sprite_arbiter.sv
// Sprite arbiter: several on-screen sprite slots share one sprite ROM through a fixed 3-stage pixel pipeline.
// Optional feature: define SPRITE_ARB_OVERLAP_EN to report sprite overlap from the previous frame.
module sprite_arbiter #(
  parameter int NUM_SLOTS = 4,
  parameter int SPR_W     = 20,
  parameter int SPR_H     = 14,
  parameter int ADDR_W    = 9
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [1:0]        upd_slot,
  input  logic [9:0]        upd_x,
  input  logic [9:0]        upd_y,
  input  logic              upd_active,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic              pix_valid,
  output logic [7:0]        pix_index,
  output logic [1:0]        pix_slot,
  output logic              overlap
);

  logic [9:0]           r_shX   [NUM_SLOTS];
  logic [9:0]           r_shY   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_shAct;
  logic [9:0]           r_actX  [NUM_SLOTS];
  logic [9:0]           r_actY  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_actAct;

  logic                 r_s0Valid;
  logic [9:0]           r_s0X;
  logic [9:0]           r_s0Y;
  logic                 r_s0Blank;
  logic                 r_s1Valid;
  logic                 r_s1Hit;
  logic [1:0]           r_s1Slot;
  logic [ADDR_W-1:0]    r_romAddr;
  logic                 r_s2Valid;
  logic                 r_s2Hit;
  logic [1:0]           r_s2Slot;
  logic                 r_pixValid;
  logic [7:0]           r_pixIndex;
  logic [1:0]           r_pixSlot;

  logic                 w_accept;
  logic [NUM_SLOTS-1:0] w_hitVec;
  logic                 w_anyHit;
  logic [1:0]           w_winSlot;
  logic [9:0]           w_winX;
  logic [9:0]           w_winY;
  logic [9:0]           w_dx;
  logic [9:0]           w_dy;
  logic [ADDR_W-1:0]    w_addr;

  // Updates are refused while the shadow set is being copied, so a copy never races a write.
  assign upd_ready = !reset && !frame_start;
  assign w_accept  = upd_valid && upd_ready;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_shX[i]  <= '0;
        r_shY[i]  <= '0;
        r_actX[i] <= '0;
        r_actY[i] <= '0;
      end
      r_shAct  <= '0;
      r_actAct <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_actX[i] <= r_shX[i];
        r_actY[i] <= r_shY[i];
      end
      r_actAct <= r_shAct;
    end else if (w_accept) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (upd_slot == 2'(i)) begin
          r_shX[i]   <= upd_x;
          r_shY[i]   <= upd_y;
          r_shAct[i] <= upd_active;
        end
      end
    end
  end

  // Sprite end coordinates are formed at 11 bits so sprites near the right/bottom edge clip instead of wrapping.
  always_comb begin
    w_hitVec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_hitVec[i] = r_actAct[i] && r_s0Blank
                    && (r_s0X >= r_actX[i])
                    && ({1'b0, r_s0X} < ({1'b0, r_actX[i]} + 11'(SPR_W)))
                    && (r_s0Y >= r_actY[i])
                    && ({1'b0, r_s0Y} < ({1'b0, r_actY[i]} + 11'(SPR_H)));
    end
  end

  // Scanning downwards lets the lowest-numbered hitting slot overwrite any higher one.
  always_comb begin
    w_anyHit  = 1'b0;
    w_winSlot = '0;
    w_winX    = '0;
    w_winY    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_hitVec[i]) begin
        w_anyHit  = 1'b1;
        w_winSlot = 2'(i);
        w_winX    = r_actX[i];
        w_winY    = r_actY[i];
      end
    end
  end

  assign w_dx   = r_s0X - w_winX;
  assign w_dy   = r_s0Y - w_winY;
  assign w_addr = ADDR_W'(w_dy) * ADDR_W'(SPR_W) + ADDR_W'(w_dx);

  // Stage 0 samples the pixel, stage 1 issues the ROM address, stage 2 waits out the ROM, stage 3 presents the pixel.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_s0Valid  <= 1'b0;
      r_s0X      <= '0;
      r_s0Y      <= '0;
      r_s0Blank  <= 1'b0;
      r_s1Valid  <= 1'b0;
      r_s1Hit    <= 1'b0;
      r_s1Slot   <= '0;
      r_romAddr  <= '0;
      r_s2Valid  <= 1'b0;
      r_s2Hit    <= 1'b0;
      r_s2Slot   <= '0;
      r_pixValid <= 1'b0;
      r_pixIndex <= '0;
      r_pixSlot  <= '0;
    end else begin
      r_s0Valid <= 1'b1;
      r_s0X     <= DrawX;
      r_s0Y     <= DrawY;
      r_s0Blank <= blank;

      r_s1Valid <= r_s0Valid;
      r_s1Hit   <= r_s0Valid && w_anyHit;
      r_s1Slot  <= (r_s0Valid && w_anyHit) ? w_winSlot : 2'd0;
      r_romAddr <= (r_s0Valid && w_anyHit) ? w_addr : '0;

      r_s2Valid <= r_s1Valid;
      r_s2Hit   <= r_s1Hit;
      r_s2Slot  <= r_s1Slot;

      if (r_s2Valid && r_s2Hit && (rom_q != 8'd0)) begin
        r_pixValid <= 1'b1;
        r_pixIndex <= rom_q;
        r_pixSlot  <= r_s2Slot;
      end else begin
        r_pixValid <= 1'b0;
        r_pixIndex <= '0;
        r_pixSlot  <= '0;
      end
    end
  end

  assign rom_address = r_romAddr;
  assign pix_valid   = r_pixValid;
  assign pix_index   = r_pixIndex;
  assign pix_slot    = r_pixSlot;

`ifdef SPRITE_ARB_OVERLAP_EN
  logic w_multi;
  logic r_sticky;
  logic r_overlap;

  // Clearing the lowest set bit leaves something only when two or more slots hit.
  assign w_multi = |(w_hitVec & (w_hitVec - NUM_SLOTS'(1)));

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_sticky  <= 1'b0;
      r_overlap <= 1'b0;
    end else if (frame_start) begin
      r_overlap <= r_sticky;
      r_sticky  <= 1'b0;
    end else if (r_s0Valid && w_multi) begin
      r_sticky <= 1'b1;
    end
  end

  assign overlap = r_overlap;
`else
  assign overlap = 1'b0;
`endif

endmodule
